// File: rtl/fetch_queue_pkg.sv
// rtl/fetch_queue_pkg.sv - shared widths, fetch step and sizing helper for the fetch queue
package fetch_queue_pkg;

  localparam int PC_ADDR_WIDTH = 16;
  localparam int IR_WIDTH      = 32;
  localparam int FQ_DEPTH      = 4;
  localparam int PC_INC        = 4;

  // Count needs one extra bit so that "full" (== DEPTH) is representable.
  function automatic int fq_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - instruction-memory and decode-side signals of the fetch queue
interface fetch_queue_if
  import fetch_queue_pkg::*;
#(
  parameter int PC_W   = PC_ADDR_WIDTH,
  parameter int INST_W = IR_WIDTH
) ();

  logic              imem_req;
  logic [PC_W-1:0]   imem_addr;
  logic [INST_W-1:0] imem_rdata;
  logic              redirect;
  logic [PC_W-1:0]   redirect_pc;
  logic              out_valid;
  logic [INST_W-1:0] out_inst;
  logic [PC_W-1:0]   out_pc;
  logic              out_ready;

  modport master (
    output imem_req, imem_addr, out_valid, out_inst, out_pc,
    input  imem_rdata, redirect, redirect_pc, out_ready
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_inst, out_pc,
    output imem_rdata, redirect, redirect_pc, out_ready
  );

endinterface

// File: rtl/fq_fifo.sv
// rtl/fq_fifo.sv - circular entry storage with flush; head is read straight from registers
module fq_fifo
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH,
  parameter int W     = PC_ADDR_WIDTH + IR_WIDTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push,
  input  logic                        pop,
  input  logic                        flush,
  input  logic [W-1:0]                data_in,
  output logic [W-1:0]                data_out,
  output logic [fq_cnt_w(DEPTH)-1:0]  count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = fq_cnt_w(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && ((count_q != FULL) || do_pop);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) tail_d = tail_q + AW'(1);
      if (do_pop)  head_d = head_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload needs no reset: it is only visible while count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push && !flush && !reset) mem_q[tail_q] <= data_in;
  end

  assign data_out = mem_q[head_q];
  assign count    = count_q;

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - sequential fetch with one-deep memory pipeline, redirect squash and decode queue
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH  = FQ_DEPTH,
  parameter int PC_W   = PC_ADDR_WIDTH,
  parameter int INST_W = IR_WIDTH
) (
  input  logic          clk,
  input  logic          reset,
  fetch_queue_if.master bus
);

  localparam int CW = fq_cnt_w(DEPTH);
  localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
  localparam logic [PC_W-1:0] PC_STEP = PC_W'(PC_INC);

  logic [PC_W-1:0]        fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0]        infl_pc_q, infl_pc_d;
  logic                   inflight_q, inflight_d;
  logic                   infl_epoch_q, infl_epoch_d;
  logic                   epoch_q, epoch_d;
  logic [CW-1:0]          count;
  logic [PC_W+INST_W-1:0] head;
  logic                   issue, push, pop;

  // The in-flight slot is reserved up front so a returning word always has room.
  assign issue = !reset && !bus.redirect && ((count + CW'(inflight_q)) < DEPTH_C);
  assign push  = inflight_q && (infl_epoch_q == epoch_q) && !bus.redirect;
  assign pop   = bus.out_valid && bus.out_ready && !bus.redirect;

  assign bus.imem_req  = issue;
  assign bus.imem_addr = fetch_pc_q;
  assign bus.out_valid = !reset && (count != '0);
  assign bus.out_pc    = bus.out_valid ? head[PC_W+INST_W-1:INST_W] : '0;
  assign bus.out_inst  = bus.out_valid ? head[INST_W-1:0] : '0;

  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    infl_pc_d    = infl_pc_q;
    infl_epoch_d = infl_epoch_q;
    epoch_d      = epoch_q;
    inflight_d   = issue;
    if (bus.redirect) begin
      fetch_pc_d = {bus.redirect_pc[PC_W-1:2], 2'b00};
      epoch_d    = ~epoch_q;
      inflight_d = 1'b0;
    end else if (issue) begin
      fetch_pc_d   = fetch_pc_q + PC_STEP;
      infl_pc_d    = fetch_pc_q;
      infl_epoch_d = epoch_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q   <= '0;
      infl_pc_q    <= '0;
      inflight_q   <= 1'b0;
      infl_epoch_q <= 1'b0;
      epoch_q      <= 1'b0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      infl_pc_q    <= infl_pc_d;
      inflight_q   <= inflight_d;
      infl_epoch_q <= infl_epoch_d;
      epoch_q      <= epoch_d;
    end
  end

  fq_fifo #(
    .DEPTH (DEPTH),
    .W     (PC_W + INST_W)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .flush    (bus.redirect),
    .data_in  ({infl_pc_q, bus.imem_rdata}),
    .data_out (head),
    .count    (count)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - scoreboard bench for fetch_queue with a one-cycle instruction memory model
module tb_fetch_queue;

  localparam int DEPTH  = 4;
  localparam int PC_W   = 16;
  localparam int INST_W = 32;
  localparam int EW     = PC_W + INST_W;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_queue_if #(.PC_W(PC_W), .INST_W(INST_W)) bus ();

  fetch_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .INST_W(INST_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp_e;

  function automatic logic [INST_W-1:0] mem_word(input logic [PC_W-1:0] a);
    return 32'h1000_0000 + {26'd0, a[7:2]};
  endfunction

  always @(posedge clk)
    bus.imem_rdata <= bus.imem_req ? mem_word(bus.imem_addr) : 32'hDEAD_BEEF;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [PC_W-1:0] pc0, input int n);
    logic [PC_W-1:0] pc;
    for (int i = 0; i < n; i++) begin
      pc = pc0 + PC_W'(4 * i);
      exp_q.push_back({pc, mem_word(pc)});
    end
  endtask

  task automatic apply_reset();
    reset           = 1'b1;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.out_ready   = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset           = 1'b1;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.out_ready   = 1'b1;
    repeat (3) tick();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_imem_req: got %b want 0", bus.imem_req); end
    n_cmp++; if (bus.out_inst !== '0) begin n_fail++; $display("FAIL reset_out_inst: got %h want 0", bus.out_inst); end
    n_cmp++; if (bus.out_pc !== '0) begin n_fail++; $display("FAIL reset_out_pc: got %h want 0", bus.out_pc); end
    n_cmp++; if (bus.imem_addr !== '0) begin n_fail++; $display("FAIL reset_imem_addr: got %h want 0", bus.imem_addr); end
  endtask

  task automatic test_stream();
    apply_reset();
    n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0000) begin n_fail++; $display("FAIL stream_first_req: got req=%b addr=%h want req=1 addr=0000", bus.imem_req, bus.imem_addr); end
    bus.out_ready = 1'b1;
    push_exp(16'h0000, 11);
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (k == 1) begin
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_latency: out_valid=%b at cycle 1, want 0", bus.out_valid); end
      end else begin
        exp_e = exp_q.pop_front();
        n_cmp++;
        if (bus.out_valid !== 1'b1 || {bus.out_pc, bus.out_inst} !== exp_e) begin
          n_fail++;
          $display("FAIL stream_cycle%0d: got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h", k, bus.out_valid, bus.out_pc, bus.out_inst, exp_e[EW-1:INST_W], exp_e[INST_W-1:0]);
        end
      end
    end
  endtask

  task automatic test_stall();
    int reqs;
    int guard;
    apply_reset();
    reqs = 0;
    for (int k = 0; k < 10; k++) begin
      if (bus.imem_req === 1'b1) reqs++;
      tick();
    end
    n_cmp++; if (reqs != DEPTH) begin n_fail++; $display("FAIL stall_req_count: got %0d want %0d", reqs, DEPTH); end
    n_cmp++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_req_low: got %b want 0", bus.imem_req); end
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 16'h0000) begin n_fail++; $display("FAIL stall_head: got v=%b pc=%h want v=1 pc=0000", bus.out_valid, bus.out_pc); end
    push_exp(16'h0000, 8);
    bus.out_ready = 1'b1;
    guard = 0;
    while (exp_q.size() > 0 && guard < 40) begin
      if (bus.out_valid === 1'b1) begin
        exp_e = exp_q.pop_front();
        n_cmp++;
        if ({bus.out_pc, bus.out_inst} !== exp_e) begin n_fail++; $display("FAIL stall_data: got pc=%h inst=%h want pc=%h inst=%h", bus.out_pc, bus.out_inst, exp_e[EW-1:INST_W], exp_e[INST_W-1:0]); end
      end
      tick();
      guard++;
    end
    n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL stall_timeout: %0d entries missing want 0", exp_q.size()); end
  endtask

  task automatic test_redirect();
    int guard;
    apply_reset();
    repeat (4) tick();
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 16'h0000) begin n_fail++; $display("FAIL redir_pre_head: got v=%b pc=%h want v=1 pc=0000", bus.out_valid, bus.out_pc); end
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0043;
    tick();
    bus.redirect = 1'b0;
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL redir_flush: out_valid=%b want 0", bus.out_valid); end
    n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0040) begin n_fail++; $display("FAIL redir_target: got req=%b addr=%h want req=1 addr=0040", bus.imem_req, bus.imem_addr); end
    bus.out_ready = 1'b1;
    push_exp(16'h0040, 4);
    tick();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL redir_early: out_valid=%b two cycles after redirect, want 0", bus.out_valid); end
    tick();
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL redir_latency: out_valid=%b three cycles after redirect, want 1", bus.out_valid); end
    guard = 0;
    while (exp_q.size() > 0 && guard < 40) begin
      if (bus.out_valid === 1'b1) begin
        exp_e = exp_q.pop_front();
        n_cmp++;
        if ({bus.out_pc, bus.out_inst} !== exp_e) begin n_fail++; $display("FAIL redir_data: got pc=%h inst=%h want pc=%h inst=%h", bus.out_pc, bus.out_inst, exp_e[EW-1:INST_W], exp_e[INST_W-1:0]); end
      end
      tick();
      guard++;
    end
    n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL redir_timeout: %0d entries missing want 0", exp_q.size()); end
  endtask

  task automatic test_redirect_full();
    int guard;
    int waited;
    apply_reset();
    repeat (10) tick();
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL full_state: got v=%b req=%b want v=1 req=0", bus.out_valid, bus.imem_req); end
    bus.out_ready   = 1'b1;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0100;
    tick();
    bus.redirect = 1'b0;
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL full_flush: out_valid=%b want 0", bus.out_valid); end
    n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0100) begin n_fail++; $display("FAIL full_target: got req=%b addr=%h want req=1 addr=0100", bus.imem_req, bus.imem_addr); end
    push_exp(16'h0100, 3);
    waited = 0;
    while (bus.out_valid !== 1'b1 && waited < 10) begin
      tick();
      waited++;
    end
    n_cmp++; if (waited != 2) begin n_fail++; $display("FAIL full_latency: waited %0d cycles want 2", waited); end
    guard = 0;
    while (exp_q.size() > 0 && guard < 40) begin
      if (bus.out_valid === 1'b1) begin
        exp_e = exp_q.pop_front();
        n_cmp++;
        if ({bus.out_pc, bus.out_inst} !== exp_e) begin n_fail++; $display("FAIL full_data: got pc=%h inst=%h want pc=%h inst=%h", bus.out_pc, bus.out_inst, exp_e[EW-1:INST_W], exp_e[INST_W-1:0]); end
      end
      tick();
      guard++;
    end
    n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL full_timeout: %0d entries missing want 0", exp_q.size()); end
  endtask

  task automatic test_wrap();
    int guard;
    apply_reset();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'hFFF8;
    bus.out_ready   = 1'b1;
    tick();
    bus.redirect = 1'b0;
    push_exp(16'hFFF8, 4);
    guard = 0;
    while (exp_q.size() > 0 && guard < 40) begin
      if (bus.out_valid === 1'b1) begin
        exp_e = exp_q.pop_front();
        n_cmp++;
        if ({bus.out_pc, bus.out_inst} !== exp_e) begin n_fail++; $display("FAIL wrap_data: got pc=%h inst=%h want pc=%h inst=%h", bus.out_pc, bus.out_inst, exp_e[EW-1:INST_W], exp_e[INST_W-1:0]); end
      end
      tick();
      guard++;
    end
    n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL wrap_timeout: %0d entries missing want 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    int guard;
    apply_reset();
    bus.out_ready = 1'b1;
    repeat (6) tick();
    reset = 1'b1;
    tick();
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL midreset_outputs: got v=%b req=%b want v=0 req=0", bus.out_valid, bus.imem_req); end
    reset = 1'b0;
    #1;
    n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0000) begin n_fail++; $display("FAIL midreset_restart: got req=%b addr=%h want req=1 addr=0000", bus.imem_req, bus.imem_addr); end
    push_exp(16'h0000, 4);
    guard = 0;
    while (exp_q.size() > 0 && guard < 40) begin
      if (bus.out_valid === 1'b1) begin
        exp_e = exp_q.pop_front();
        n_cmp++;
        if ({bus.out_pc, bus.out_inst} !== exp_e) begin n_fail++; $display("FAIL midreset_data: got pc=%h inst=%h want pc=%h inst=%h", bus.out_pc, bus.out_inst, exp_e[EW-1:INST_W], exp_e[INST_W-1:0]); end
      end
      tick();
      guard++;
    end
    n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL midreset_timeout: %0d entries missing want 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_full();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning queue entries (power of two, 2..16).
REQ-002 The block SHALL have parameter PC_W, default 16, meaning PC byte-address width.
REQ-003 The block SHALL have parameter INST_W, default 32, meaning instruction word width.
REQ-004 The block SHALL have port clk  input  1  meaning the single clock; all state changes on posedge clk.
REQ-005 The block SHALL have port reset  input  1  meaning synchronous, active-high reset.
REQ-006 The block SHALL have port imem_req  output  1  meaning an instruction-memory read is issued this cycle.
REQ-007 The block SHALL have port imem_addr  output  PC_W  meaning byte address of the read (memory indexes addr[7:2]).
REQ-008 The block SHALL have port imem_rdata  input  INST_W  meaning read data, valid exactly one cycle after imem_req.
REQ-009 The block SHALL have port redirect  input  1  meaning branch/jump taken; flush and refetch.
REQ-010 The block SHALL have port redirect_pc  input  PC_W  meaning new fetch target.
REQ-011 The block SHALL have port out_valid  output  1  meaning head entry is available to decode.
REQ-012 The block SHALL have port out_inst  output  INST_W  meaning head instruction word.
REQ-013 The block SHALL have port out_pc  output  PC_W  meaning byte PC of head instruction.
REQ-014 The block SHALL have port out_ready  input  1  meaning decode consumes head this cycle.

Function
REQ-015 fetch_pc SHALL be held internally; imem_addr SHALL equal fetch_pc combinationally.
REQ-016 imem_req SHALL assert when not redirect and (count + inflight) < DEPTH; inflight is 0 or 1.
REQ-017 Each issued request SHALL advance fetch_pc by 4 modulo 2^PC_W (0xFFFC wraps to 0x0000).
REQ-018 One cycle after an issued, non-squashed request, imem_rdata and its PC SHALL be written at the tail.
REQ-019 out_valid SHALL equal (count != 0); out_inst/out_pc SHALL reflect the head entry, registered storage, no bypass.
REQ-020 Pop SHALL occur when out_valid and out_ready; out_ready with out_valid low SHALL be ignored.
REQ-021 Simultaneous push and pop SHALL leave count unchanged and preserve order, including at full.
REQ-022 Head/tail pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH nor underflow.
REQ-023 Redirect SHALL, at that edge: clear count and pointers, mark any inflight response squashed, load fetch_pc with {redirect_pc[PC_W-1:2],2'b00}.
REQ-024 Redirect SHALL take priority over push and pop in the same cycle; no pop is reported to decode.
REQ-025 The response returning the cycle after a redirect SHALL be discarded (epoch bit toggled on redirect, tagged per request).
REQ-026 The first request for redirect_pc SHALL issue the cycle after redirect (redirect-to-first-out_valid = 3 cycles).
REQ-027 Steady-state throughput SHALL be one instruction per cycle when out_ready is held high.
REQ-028 Latency from reset release to first out_valid SHALL be 2 cycles (request cycle, capture cycle).

Reset
REQ-029 On reset: fetch_pc=0, count=0, pointers=0, inflight=0, epoch=0.
REQ-030 During reset: imem_req=0, out_valid=0; out_inst and out_pc SHALL read 0.
REQ-031 Reset asserted mid-operation SHALL discard all entries and any inflight response, overriding redirect.

Structure
REQ-032 PC_W, INST_W default values and the PC increment constant (4) SHALL live in global_def.h alongside PC_ADDR_WIDTH/IR_WIDTH.
REQ-033 Storage SHALL be a sub-module fq_fifo (push, pop, flush, data_in, data_out, count); fetch_queue holds PC, inflight and epoch logic.

Verification
REQ-034 Reset release, out_ready=1, mem[i]=0x1000_0000+i -> out_pc 0,4,8,... one per cycle from cycle 2, matching words in order.
REQ-035 out_ready=0 for 10 cycles -> exactly DEPTH (4) entries captured, imem_req low once count+inflight=4, no loss on resume.
REQ-036 redirect with redirect_pc=0x0043 while queue holds 3 entries and 1 inflight -> inflight word dropped, next out_pc=0x0040 after 3 cycles.
REQ-037 redirect and out_ready in same cycle at full -> no pop, queue empty next cycle, fetch resumes at target.
REQ-038 fetch_pc=0xFFF8 with continuous consume -> out_pc 0xFFF8, 0xFFFC, 0x0000.
REQ-039 reset asserted for one cycle mid-stream -> out_valid 0 next cycle, stale inflight word never appears, restart at PC 0.
